// File: rtl/cordic_pkg.sv
// cordic_pkg: constants and types shared by the CORDIC blocks (vectorize, rotate).
// Phase uses 2^32 per full turn, so PI = 32'h8000_0000.
// Holds the arctangent table, the 1/K gain constant and the datapath width.
package cordic_pkg;

    // Working width of the x/y datapath: 16-bit samples sign-extended to 18 bits.
    // This leaves headroom for the pre-rotation negation of -32768 and for the
    // CORDIC gain of ~1.65 applied to a vector of length up to sqrt(2)*32768.
    localparam int XW = 18;

    localparam logic [31:0] PI   = 32'h8000_0000;
    localparam logic [31:0] PI_2 = 32'h4000_0000;
    localparam logic [31:0] PI_4 = 32'h2000_0000;

    // 1/K ~ 0.60725 in Q1.15.
    localparam logic [15:0] INV_K = 16'd19899;

    // ATAN[i] = round(atan(2^-i) * 2^31 / pi).
    localparam logic [31:0] ATAN [16] = '{
        32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
        32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
        32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
        32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D
    };

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ITER  = 3'd2,
        SCALE = 3'd3,
        DONE  = 3'd4
    } vec_state_t;

    // Clamp a non-negative wide magnitude to 16 bits.
    function automatic logic [15:0] sat_u16(input logic [19:0] v);
        return (v > 20'h0_FFFF) ? 16'hFFFF : v[15:0];
    endfunction

endpackage

// File: rtl/cordic_step.sv
// cordic_step: one vectoring-mode CORDIC micro-rotation, purely combinational.
// Ports: x, y (signed XW), phase, shift index, atan entry in; x_next, y_next, phase_next out.
// Direction d = sign(y) with y == 0 treated as positive; shifts are arithmetic, phase wraps.
module cordic_step
    import cordic_pkg::*;
(
    input  logic signed [XW-1:0] x,
    input  logic signed [XW-1:0] y,
    input  logic        [31:0]   phase,
    input  logic        [3:0]    shift,
    input  logic        [31:0]   atan,
    output logic signed [XW-1:0] x_next,
    output logic signed [XW-1:0] y_next,
    output logic        [31:0]   phase_next
);

    logic signed [XW-1:0] x_sh;
    logic signed [XW-1:0] y_sh;

    assign x_sh = x >>> shift;
    assign y_sh = y >>> shift;

    always_comb begin
        x_next     = x;
        y_next     = y;
        phase_next = phase;
        if (y[XW-1]) begin
            // d = -1: rotate counter-clockwise, accumulated phase decreases
            x_next     = x - y_sh;
            y_next     = y + x_sh;
            phase_next = phase - atan;
        end else begin
            // d = +1: rotate clockwise, accumulated phase increases
            x_next     = x + y_sh;
            y_next     = y - x_sh;
            phase_next = phase + atan;
        end
    end

endmodule

// File: rtl/vectorize.sv
// vectorize: Cartesian {imag, real} Q1.15 sample in, polar {phase[31:0], mag[15:0]} out.
// Ports: clk, reset (sync, active-high), s_valid/s_ready/s_data[31:0], m_valid/m_ready/m_data[47:0].
// Latency ITERATIONS+3 cycles, one sample in flight; macro VECTORIZE_GAIN_COMP_EN enables 1/K scaling.
module vectorize
    import cordic_pkg::*;
#(
    parameter int ITERATIONS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [47:0] m_data
);

    localparam logic [3:0] LAST = 4'(ITERATIONS - 1);

    vec_state_t state;
    vec_state_t state_next;

    logic [31:0]          sample;
    logic signed [XW-1:0] x;
    logic signed [XW-1:0] y;
    logic [31:0]          phase;
    logic [31:0]          phase_init;
    logic                 on_axis;
    logic [3:0]           cnt;

    logic signed [XW-1:0] re;
    logic signed [XW-1:0] im;
    logic signed [XW-1:0] x_step;
    logic signed [XW-1:0] y_step;
    logic [31:0]          phase_step;
    logic [19:0]          mag_wide;
    logic [15:0]          mag;
    logic [31:0]          phase_out;

    assign re = {{(XW-16){sample[15]}}, sample[15:0]};
    assign im = {{(XW-16){sample[31]}}, sample[31:16]};

    cordic_step u_step (
        .x          (x),
        .y          (y),
        .phase      (phase),
        .shift      (cnt),
        .atan       (ATAN[cnt]),
        .x_next     (x_step),
        .y_next     (y_step),
        .phase_next (phase_step)
    );

    // Control: state and handshakes
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        s_ready    = 1'b0;
        m_valid    = 1'b0;
        case (state)
            IDLE: begin
                s_ready = !reset;
                if (s_valid && !reset) state_next = LOAD;
            end
            LOAD:  state_next = ITER;
            ITER:  if (cnt == LAST) state_next = SCALE;
            SCALE: state_next = DONE;
            DONE: begin
                m_valid = 1'b1;
                if (m_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Magnitude scaling; x is never negative after pre-rotation but is clamped anyway.
    always_comb begin
        mag_wide = '0;
        if (!x[XW-1]) begin
`ifdef VECTORIZE_GAIN_COMP_EN
            mag_wide = 20'((34'(x[XW-2:0]) * 34'(INV_K) + 34'd16384) >> 15);
`else
            mag_wide = 20'(x[XW-2:1]);
`endif
        end
        mag = sat_u16(mag_wide);
    end

    // On-axis inputs (imag == 0) have an exactly known phase of 0 or PI; the
    // iterations would otherwise dither around the axis and leave a small residual.
    assign phase_out = on_axis ? phase_init : phase;

    // Datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            m_data <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (s_valid && s_ready) sample <= s_data;
                end
                LOAD: begin
                    // Fold the left half-plane into the right so the
                    // micro-rotations only need to cover +/- 99.9 degrees.
                    if (re[XW-1]) begin
                        x          <= -re;
                        y          <= -im;
                        phase      <= PI;
                        phase_init <= PI;
                    end else begin
                        x          <= re;
                        y          <= im;
                        phase      <= '0;
                        phase_init <= '0;
                    end
                    on_axis <= (im == '0);
                    cnt     <= '0;
                end
                ITER: begin
                    x     <= x_step;
                    y     <= y_step;
                    phase <= phase_step;
                    cnt   <= cnt + 4'd1;
                end
                SCALE: begin
                    m_data <= {phase_out, mag};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vectorize.sv
// tb_vectorize: directed scoreboard bench for vectorize.
// Expected phase/magnitude pushed on accept, popped and compared when m_valid appears.
// Covers latency, axis/quadrant cases, -32768, zero, output stall, and reset aborts.
module tb_vectorize;

    localparam int N = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        m_valid;
    logic        m_ready;
    logic [47:0] m_data;

    int  checks = 0;
    int  errors = 0;
    real gain;
    int  mtol;

    logic [31:0] q_ph[$];
    int          q_ptol[$];
    int          q_mag[$];
    string       q_tag[$];

    always #5 clk = ~clk;

    vectorize #(.ITERATIONS(N)) dut (
        .clk     (clk),
        .reset   (reset),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data)
    );

    task automatic chk_val(input string tag, input longint obs, input longint expv, input longint tol);
        checks++;
        assert ((obs - expv) <= tol && (expv - obs) <= tol)
        else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d (tol %0d)", tag, obs, expv, tol);
        end
    endtask

    task automatic chk_ph(input string tag, input logic [31:0] obs, input logic [31:0] expv, input int tol);
        logic signed [31:0] d;
        d = obs - expv;
        checks++;
        assert (d <= tol && d >= -tol)
        else begin
            errors++;
            $error("FAIL %s phase observed %h expected %h (tol %0d)", tag, obs, expv, tol);
        end
    endtask

    task automatic send(input string tag, input int re, input int im,
                        input logic [31:0] ph, input int ptol, input real r);
        int w;
        w = 0;
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = {16'(im), 16'(re)};
        while (!s_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk_val($sformatf("%s accept", tag), longint'(s_ready), 1, 0);
        @(posedge clk);
        #1 s_valid = 1'b0;
        q_ph.push_back(ph);
        q_ptol.push_back(ptol);
        q_mag.push_back($rtoi(r * gain + 0.5));
        q_tag.push_back(tag);
    endtask

    task automatic recv(input int hold, output logic [47:0] got);
        int    cyc;
        bit    stable;
        bit    rdy_low;
        string t;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!m_valid && cyc < 200);
        t = q_tag.pop_front();
        chk_val($sformatf("%s latency", t), cyc, N + 3, 0);
        got = m_data;
        chk_ph(t, m_data[47:16], q_ph.pop_front(), q_ptol.pop_front());
        chk_val($sformatf("%s mag", t), longint'(m_data[15:0]), q_mag.pop_front(), mtol);
        if (hold > 0) begin
            stable  = 1'b1;
            rdy_low = 1'b1;
            repeat (hold) begin
                @(negedge clk);
                if (m_data !== got || m_valid !== 1'b1) stable = 1'b0;
                if (s_ready !== 1'b0) rdy_low = 1'b0;
            end
            chk_val($sformatf("%s stall m_data stable", t), longint'(stable), 1, 0);
            chk_val($sformatf("%s stall s_ready low", t), longint'(rdy_low), 1, 0);
        end
        m_ready = 1'b1;
        @(posedge clk);
        #1 m_ready = 1'b0;
        chk_val($sformatf("%s s_ready after handshake", t), longint'(s_ready), 1, 0);
    endtask

    // Accept a sample, then reset after 'delay' negedges; nothing may come out.
    task automatic abort(input string tag, input int delay);
        bit seen;
        send(tag, 12000, -7000, 32'h0, 0, 0.0);
        void'(q_ph.pop_front());
        void'(q_ptol.pop_front());
        void'(q_mag.pop_front());
        void'(q_tag.pop_front());
        repeat (delay) @(negedge clk);
        reset = 1'b1;
        #1 chk_val($sformatf("%s s_ready in reset", tag), longint'(s_ready), 0, 0);
        @(negedge clk);
        chk_val($sformatf("%s m_valid after reset", tag), longint'(m_valid), 0, 0);
        chk_val($sformatf("%s m_data after reset", tag), longint'(m_data), 0, 0);
        reset = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (m_valid) seen = 1'b1;
        end
        chk_val($sformatf("%s no output", tag), longint'(seen), 0, 0);
    endtask

    initial begin
        logic [47:0] got;
        real         k;
        real         mr;
        real         ang;
        k = 1.0;
        for (int i = 0; i < N; i++) k = k * $sqrt(1.0 + 2.0 ** (-2.0 * i));
`ifdef VECTORIZE_GAIN_COMP_EN
        gain = 1.0;
        mtol = 4;
`else
        gain = k / 2.0;
        mtol = 6;
`endif
        reset   = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_val("reset s_ready", longint'(s_ready), 0, 0);
        chk_val("reset m_valid", longint'(m_valid), 0, 0);
        chk_val("reset m_data", longint'(m_data), 0, 0);
        reset = 1'b0;
        @(negedge clk);
        chk_val("idle s_ready", longint'(s_ready), 1, 0);

        send("re16384", 16384, 0, 32'h0000_0000, 1 << 17, 16384.0);
        recv(0, got);

        send("im16384", 0, 16384, 32'h4000_0000, 1 << 17, 16384.0);
        recv(10, got);

        send("q2", -16384, 16384, 32'h6000_0000, 1 << 17, 16384.0 * $sqrt(2.0));
        recv(0, got);
        mr  = real'(got[15:0]) / gain;
        ang = real'(got[47:16]) * 2.0 * 3.14159265358979 / 4294967296.0;
        chk_val("q2 roundtrip real", longint'($rtoi(mr * $cos(ang) + ((mr * $cos(ang)) < 0 ? -0.5 : 0.5))), -16384, 4);
        chk_val("q2 roundtrip imag", longint'($rtoi(mr * $sin(ang) + ((mr * $sin(ang)) < 0 ? -0.5 : 0.5))), 16384, 4);

        send("neg_full", -32768, 0, 32'h8000_0000, 0, 32768.0);
        recv(0, got);

        send("zero", 0, 0, 32'h0000_0000, 0, 0.0);
        recv(0, got);

        abort("rst_iter", 8);
        send("after_rst_iter", 16384, 0, 32'h0000_0000, 1 << 17, 16384.0);
        recv(0, got);

        abort("rst_done", N + 5);
        send("after_rst_done", 0, -16384, 32'hC000_0000, 1 << 17, 16384.0);
        recv(0, got);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
